// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(t=3) decoder over GF(2^8).
package rs_pkg;

  localparam int unsigned SYM_W = 8;
  localparam int unsigned T     = 3;
  localparam int unsigned NSYN  = 2 * T;
  localparam int unsigned NLOC  = T + 1;

  localparam logic [7:0] GF_ONE = 8'h01;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StLaunch,
    StWait,
    StOut
  } bm_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bm_scheduler.sv
// Sequences the Berlekamp-Massey unit between syndrome calculation and Chien search,
// with an all-zero bypass, a completion timeout and saturating statistics.
module bm_scheduler #(
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             syn_valid,
  output logic             syn_ready,
  input  logic [SYM_W-1:0] syn1,
  input  logic [SYM_W-1:0] syn2,
  input  logic [SYM_W-1:0] syn3,
  input  logic [SYM_W-1:0] syn4,
  input  logic [SYM_W-1:0] syn5,
  input  logic [SYM_W-1:0] syn6,
  output logic             bm_signal,
  output logic [SYM_W-1:0] bm_S1,
  output logic [SYM_W-1:0] bm_S2,
  output logic [SYM_W-1:0] bm_S3,
  output logic [SYM_W-1:0] bm_S4,
  output logic [SYM_W-1:0] bm_S5,
  output logic [SYM_W-1:0] bm_S6,
  input  logic             bm_ready,
  input  logic [SYM_W-1:0] bm_s0,
  input  logic [SYM_W-1:0] bm_s1,
  input  logic [SYM_W-1:0] bm_s2,
  input  logic [SYM_W-1:0] bm_s3,
  output logic             loc_valid,
  input  logic             loc_ready,
  output logic [SYM_W-1:0] loc0,
  output logic [SYM_W-1:0] loc1,
  output logic [SYM_W-1:0] loc2,
  output logic [SYM_W-1:0] loc3,
  output logic             err_free,
  output logic             fail,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  import rs_pkg::*;

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  bm_state_e                       state_q, state_d;
  logic                            init_q;
  logic                            ready_q;
  logic [WCW-1:0]                  wait_cnt_q;
  logic [NSYN-1:0][SYM_W-1:0]      syn_q;
  logic [NLOC-1:0][SYM_W-1:0]      loc_q;
  logic                            err_free_q, fail_q;

  logic accept, syn_zero, bm_done, wait_expired, dec_inc, fail_inc;

  assign accept       = syn_valid && syn_ready;
  assign syn_zero     = (syn_q == '0);
  // Completion is the 0->1 transition of bm_ready, honoured only while waiting.
  assign bm_done      = (state_q == StWait) && bm_ready && !ready_q;
  assign wait_expired = (state_q == StWait) && (wait_cnt_q == WCW'(TIMEOUT - 1));
  assign dec_inc      = (state_q == StOut) && loc_ready;
  assign fail_inc     = wait_expired && !bm_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StCheck;
      StCheck:  state_d = syn_zero ? StOut : StLaunch;
      StLaunch: state_d = StWait;
      StWait:   if (bm_done || wait_expired) state_d = StOut;
      StOut:    if (loc_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // init_q keeps syn_ready low until the first clock after reset release.
  always_comb begin
    syn_ready = init_q && (state_q == StIdle);
    bm_signal = (state_q == StLaunch);
    loc_valid = (state_q == StOut);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_q     <= 1'b0;
      ready_q    <= 1'b1;
      wait_cnt_q <= '0;
      syn_q      <= '0;
      loc_q      <= '0;
      err_free_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      ready_q <= bm_ready;
      if (accept) begin
        syn_q <= {syn6, syn5, syn4, syn3, syn2, syn1};
      end
      if (state_q == StLaunch) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + WCW'(1);
      end
      if ((state_q == StCheck) && syn_zero) begin
        loc_q      <= {{((NLOC - 1) * SYM_W){1'b0}}, SYM_W'(GF_ONE)};
        err_free_q <= 1'b1;
        fail_q     <= 1'b0;
      end else if (bm_done) begin
        loc_q      <= {bm_s3, bm_s2, bm_s1, bm_s0};
        err_free_q <= 1'b0;
        fail_q     <= 1'b0;
      end else if (wait_expired) begin
        loc_q      <= '0;
        err_free_q <= 1'b0;
        fail_q     <= 1'b1;
      end
    end
  end

  assign bm_S1    = syn_q[0];
  assign bm_S2    = syn_q[1];
  assign bm_S3    = syn_q[2];
  assign bm_S4    = syn_q[3];
  assign bm_S5    = syn_q[4];
  assign bm_S6    = syn_q[5];
  assign loc0     = loc_q[0];
  assign loc1     = loc_q[1];
  assign loc2     = loc_q[2];
  assign loc3     = loc_q[3];
  assign err_free = err_free_q;
  assign fail     = fail_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_decoded_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (dec_inc),
    .count  (decoded_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_fail_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (fail_inc),
    .count  (fail_cnt)
  );

endmodule

// File: tb/tb_bm_scheduler.sv
// Bench for bm_scheduler: BM stub, transaction-level expectation model, directed and random sets.
module tb_bm_scheduler;

  localparam int TIMEOUT = 32;
  localparam int CNT_MAX = 65535;

  typedef logic [5:0][7:0] syn_t;
  typedef logic [3:0][7:0] coef_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        syn_valid = 1'b0, loc_ready = 1'b0, bm_ready = 1'b1;
  logic        syn_ready, bm_signal, loc_valid, err_free, fail;
  logic [7:0]  syn1 = '0, syn2 = '0, syn3 = '0, syn4 = '0, syn5 = '0, syn6 = '0;
  logic [7:0]  bm_s0 = '0, bm_s1 = '0, bm_s2 = '0, bm_s3 = '0;
  logic [7:0]  bm_S1, bm_S2, bm_S3, bm_S4, bm_S5, bm_S6;
  logic [7:0]  loc0, loc1, loc2, loc3;
  logic [15:0] decoded_cnt, fail_cnt;

  int    errors = 0, checks = 0;
  int    cyc = 0, pulses = 0, pulse_cyc = 0, rise_cyc = 0, rise_in = 0;
  bit    drop_pending = 0, respond = 1;
  syn_t  pulse_syn = '0;
  int    exp_dec = 0, exp_fail = 0;

  bm_scheduler #(
    .SYM_W  (8),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syn1       (syn1),
    .syn2       (syn2),
    .syn3       (syn3),
    .syn4       (syn4),
    .syn5       (syn5),
    .syn6       (syn6),
    .bm_signal  (bm_signal),
    .bm_S1      (bm_S1),
    .bm_S2      (bm_S2),
    .bm_S3      (bm_S3),
    .bm_S4      (bm_S4),
    .bm_S5      (bm_S5),
    .bm_S6      (bm_S6),
    .bm_ready   (bm_ready),
    .bm_s0      (bm_s0),
    .bm_s1      (bm_s1),
    .bm_s2      (bm_s2),
    .bm_s3      (bm_s3),
    .loc_valid  (loc_valid),
    .loc_ready  (loc_ready),
    .loc0       (loc0),
    .loc1       (loc1),
    .loc2       (loc2),
    .loc3       (loc3),
    .err_free   (err_free),
    .fail       (fail),
    .decoded_cnt(decoded_cnt),
    .fail_cnt   (fail_cnt)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then run the BM stub for the cycle just observed.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) begin
        bm_ready = 1'b1;
        rise_cyc = cyc;
      end
    end
    if (drop_pending) begin
      drop_pending = 0;
      bm_ready = 1'b0;
      if (respond) rise_in = 10;
    end
    if (bm_signal === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
      drop_pending = 1;
      pulse_syn = {bm_S6, bm_S5, bm_S4, bm_S3, bm_S2, bm_S1};
    end
  endtask

  task automatic drive_syn(input syn_t s);
    {syn6, syn5, syn4, syn3, syn2, syn1} = s;
  endtask

  task automatic run_set(input syn_t s, input bit resp, input coef_t c, input int hold,
                         input bit offer, input syn_t nxt);
    int    n, c0, p0, exp_cyc, exp_p;
    bit    zero, ef, fl, stable, sr_low;
    coef_t el;
    logic [63:0] snap;
    respond = resp;
    {bm_s3, bm_s2, bm_s1, bm_s0} = c;
    n = 0;
    while (syn_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", syn_ready, 1);
    syn_valid = 1'b1;
    drive_syn(s);
    c0 = cyc;
    p0 = pulses;
    tick();
    syn_valid = 1'b0;
    drive_syn({$urandom, $urandom});
    n = 0;
    while (loc_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("loc_valid_seen", loc_valid, 1);
    zero = (s == '0);
    if (zero) begin
      el = {8'd0, 8'd0, 8'd0, 8'd1}; ef = 1; fl = 0; exp_cyc = c0 + 2; exp_p = 0;
    end else if (resp) begin
      el = c; ef = 0; fl = 0; exp_cyc = rise_cyc + 1; exp_p = 1;
    end else begin
      el = '0; ef = 0; fl = 1; exp_cyc = pulse_cyc + 1 + TIMEOUT; exp_p = 1;
    end
    chk("latency", cyc, exp_cyc);
    chk("pulse_count", pulses - p0, exp_p);
    if (!zero) begin
      chk("pulse_cycle", pulse_cyc, c0 + 2);
      chk("bm_syndromes", pulse_syn, s);
    end
    chk("locator", {loc3, loc2, loc1, loc0}, el);
    chk("err_free", err_free, ef);
    chk("fail", fail, fl);
    snap = {loc3, loc2, loc1, loc0, err_free, fail, loc_valid};
    stable = 1;
    sr_low = 1;
    if (offer) begin
      syn_valid = 1'b1;
      drive_syn(nxt);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if ({loc3, loc2, loc1, loc0, err_free, fail, loc_valid} !== snap) stable = 0;
      if (syn_ready !== 1'b0) sr_low = 0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_syn_ready_low", sr_low, 1);
    loc_ready = 1'b1;
    tick();
    loc_ready = 1'b0;
    exp_dec = (exp_dec == CNT_MAX) ? exp_dec : exp_dec + 1;
    if (fl) exp_fail = (exp_fail == CNT_MAX) ? exp_fail : exp_fail + 1;
    chk("loc_valid_drop", loc_valid, 0);
    chk("decoded_cnt", decoded_cnt, exp_dec);
    chk("fail_cnt", fail_cnt, exp_fail);
    if (offer) chk("next_accept_ready", syn_ready, 1);
  endtask

  initial begin
    syn_t  s;
    coef_t c;
    int    n, p0;
    bit    quiet;

    tick();
    tick();
    chk("rst_syn_ready", syn_ready, 0);
    chk("rst_loc_valid", loc_valid, 0);
    chk("rst_bm_signal", bm_signal, 0);
    chk("rst_loc", {loc3, loc2, loc1, loc0, err_free, fail}, 0);
    chk("rst_bm_S", {bm_S6, bm_S5, bm_S4, bm_S3, bm_S2, bm_S1}, 0);
    chk("rst_counters", {decoded_cnt, fail_cnt}, 0);
    reset_n = 1'b1;
    chk("release_syn_ready_low", syn_ready, 0);
    tick();
    chk("release_syn_ready", syn_ready, 1);

    run_set({8'd54, 8'd1, 8'd39, 8'd148, 8'd2, 8'd215}, 1, {8'h07, 8'h33, 8'h5A, 8'h01},
            0, 0, '0);
    run_set('0, 1, {8'h07, 8'h33, 8'h5A, 8'h01}, 0, 0, '0);
    run_set({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, {8'h07, 8'h33, 8'h5A, 8'h01}, 0, 0, '0);
    run_set({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4}, 1, {8'h07, 8'h33, 8'h5A, 8'h01},
            20, 1, {8'd239, 8'd183, 8'd248, 8'd235, 8'd105, 8'd48});
    run_set({8'd239, 8'd183, 8'd248, 8'd235, 8'd105, 8'd48}, 1, {8'h0C, 8'h44, 8'h9E, 8'h01},
            0, 0, '0);
    run_set({8'd71, 8'd39, 8'd23, 8'd15, 8'd3, 8'd5}, 1, {8'h21, 8'h00, 8'hB7, 8'h01},
            0, 0, '0);

    for (int k = 0; k < 10; k++) begin
      s = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      c = $urandom;
      run_set(s, $urandom_range(0, 4) != 0, c, $urandom_range(0, 3), 0, '0);
    end

    // Reset pulse while waiting on BM; the stub's late edge must not produce a result.
    respond = 1;
    n = 0;
    while (syn_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    syn_valid = 1'b1;
    drive_syn({8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66});
    p0 = pulses;
    tick();
    syn_valid = 1'b0;
    n = 0;
    while (pulses == p0 && n < 20) begin
      tick();
      n++;
    end
    chk("midwait_pulse_seen", pulses - p0, 1);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midwait_rst_loc_valid", loc_valid, 0);
    chk("midwait_rst_bm_signal", bm_signal, 0);
    chk("midwait_rst_syn_ready", syn_ready, 0);
    chk("midwait_rst_counters", {decoded_cnt, fail_cnt}, 0);
    exp_dec = 0;
    exp_fail = 0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("midwait_release_syn_ready", syn_ready, 1);
    quiet = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (loc_valid !== 1'b0 || bm_signal !== 1'b0) quiet = 0;
    end
    chk("midwait_no_late_capture", quiet, 1);
    chk("midwait_counters_after", {decoded_cnt, fail_cnt}, 0);
    run_set('0, 1, {8'h07, 8'h33, 8'h5A, 8'h01}, 1, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bm_scheduler.md
Name: bm_scheduler

Overview:
- Sequences the berleykamp_messey error-locator unit between the syndrome calculator (upstream) and the Chien search stage (downstream) of the RS(t=3, 6 syndromes, GF(2^8)) decoder.
- Accepts one syndrome set per handshake and bypasses the BM unit when all syndromes are zero.
- Otherwise launches BM with a one-cycle signal pulse, waits for completion with a timeout, and holds the locator for downstream with valid/ready.
- Keeps saturating decode and failure counters.

Parameters:
SYM_W, 8, symbol width in bits (GF(2^8))
TIMEOUT, 32, max WAIT cycles before declaring failure (must be >= 2)
CNT_W, 16, width of statistics counters

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
syn_valid  in  1  upstream syndrome set valid
syn_ready  out  1  scheduler can accept a syndrome set
syn1..syn6  in  SYM_W each  syndromes S1..S6
bm_signal  out  1  one-cycle start pulse to berleykamp_messey
bm_S1..bm_S6  out  SYM_W each  held syndromes driven to BM S1..S6
bm_ready  in  1  BM done: low while busy, 0->1 marks completion
bm_s0..bm_s3  in  SYM_W each  BM locator coefficients
loc_valid  out  1  locator result valid
loc_ready  in  1  downstream accepts result
loc0..loc3  out  SYM_W each  error-locator coefficients Lambda0..Lambda3
err_free  out  1  result is the zero-syndrome bypass
fail  out  1  result is a BM timeout
decoded_cnt  out  CNT_W  completed results (any kind), saturating
fail_cnt  out  CNT_W  timeouts, saturating

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-operation:
  - state=IDLE; syn_ready=0 during reset; bm_signal=0.
  - bm_S*, loc*, err_free, fail, loc_valid, counters, wait counter = 0.
  - ready_q=1.
- Reset release: syn_ready=1 from the first clock after release.
- States: IDLE, CHECK, LAUNCH, WAIT, OUT (one-hot or binary; encoding is free).
- IDLE:
  - syn_ready=1.
  - On syn_valid&syn_ready, register syn1..6 into the hold registers (which drive bm_S*), then go to CHECK.
- CHECK:
  - syn_ready=0.
  - If all six held syndromes are 0: loc0=1, loc1..3=0, err_free=1, fail=0, go to OUT.
  - Else go to LAUNCH.
- LAUNCH: bm_signal=1 for exactly this one cycle; clear the wait counter; go to WAIT.
- WAIT:
  - bm_signal=0; the wait counter increments each cycle.
  - Completion is a rising edge of bm_ready, where ready_q is bm_ready registered every cycle. On completion, capture bm_s0..3 into loc0..3, err_free=0, fail=0, go to OUT.
  - If the counter reaches TIMEOUT with no edge: loc0..3=0, fail=1, fail_cnt+1 (saturating), go to OUT.
  - If an edge and the timeout coincide in the same cycle, the edge wins (success).
- OUT:
  - loc_valid=1; loc*, err_free and fail are held stable while loc_valid&~loc_ready.
  - On loc_ready: decoded_cnt+1 (saturating), go to IDLE; loc_valid drops next cycle.
  - syn_ready stays 0 in OUT, so there is no overlap and at most one set is in flight.
- Latency:
  - Bypass: accept at cycle 0, loc_valid at cycle 2.
  - BM path: bm_signal at cycle 2; loc_valid 1 cycle after the bm_ready edge is sampled.
- bm_S* stay stable from CHECK through WAIT and are only reloaded on the next accept.
- bm_ready activity outside WAIT is ignored; an edge seen in LAUNCH does not complete.
- Counters hold at 2^CNT_W-1.

Decomposition:
- Shared package rs_pkg holds:
  - constants SYM_W=8, T=3, NSYN=2*T=6;
  - the bm_scheduler state enum;
  - localparam GF_ONE=8'h01.
- Sub-module: none required. The saturating counter may be a small shared sat_counter (CNT_W parameter), instanced twice.

Test Plan:
- Bench BM stub: bm_ready drops the cycle after bm_signal and rises 10 cycles later, with s0..s3 = 1, 0x5A, 0x33, 0x07.
- Reset mid-WAIT (reset_n low for 1 cycle during WAIT) -> loc_valid=0, bm_signal=0 immediately; counters=0; syn_ready=1 the first cycle after release; no late capture when the stub's edge arrives.
- Syndromes 215,2,148,39,1,54 with loc_ready=1 -> exactly one bm_signal pulse with bm_S1..6 equal to those values; loc0..3 = 1,0x5A,0x33,0x07 one cycle after the edge; err_free=0, fail=0; decoded_cnt=1.
- All syndromes 0 -> no bm_signal; loc_valid at cycle 2 with loc=1,0,0,0 and err_free=1.
- Stub never raises bm_ready, TIMEOUT=32 -> fail=1, loc=0,0,0,0, loc_valid 32 cycles after the WAIT entry; fail_cnt=1.
- loc_ready held 0 for 20 cycles in OUT, with new syn_valid offered -> outputs stable, syn_ready=0, second set not taken. Release -> second set accepted in the cycle after the return to IDLE.
- Back-to-back sets 48,105,235,248,183,239 then 5,3,15,23,39,71 -> two pulses, two results in order; decoded_cnt=2.
